stream_frame_mux: RTL and testbench
===================================

STREAM_FRAME_MUX -- requirements
Module: stream_frame_mux

Interface
REQ-001 Parameters: DATA_WIDTH, default 16, stream data width; NUM_SRC, default 3, number of source streams (2..4); SEL_WIDTH, default 2, select width.
REQ-002 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 enable  in  1  level; 0 = stop passing frames at the next frame boundary.
REQ-005 sel_req  in  SEL_WIDTH  requested source index, from a register.
REQ-006 dvi  in  NUM_SRC  per-source data valid.
REQ-007 dtypei  in  NUM_SRC*`DTYPE_WIDTH  per-source dtype, packed; source k at slice k.
REQ-008 datai  in  NUM_SRC*DATA_WIDTH  per-source data, packed; source k at slice k.
REQ-009 dvo  out  1  registered output valid.
REQ-010 dtypeo  out  `DTYPE_WIDTH  registered output dtype.
REQ-011 datao  out  DATA_WIDTH  registered output data.
REQ-012 active_sel  out  SEL_WIDTH  source currently granted.
REQ-013 switch_pending  out  1  sel_req differs from active_sel and no switch has been applied yet.
REQ-014 frame_count  out  16  frames passed complete; wraps 0xFFFF->0.
REQ-015 drop_count  out  16  partial frames discarded; saturates at 0xFFFF.

Function
REQ-016 States: IDLE, WAIT_START, PASS. Encoding is free.
REQ-017 IDLE: dvo=0. Go to WAIT_START when enable=1 and sel_req<NUM_SRC; latch active_sel<=sel_req.
REQ-018 WAIT_START: forward nothing. Only a beat on active_sel with dtype==FRAME_START starts a frame: forward it and go to PASS.
REQ-019 WAIT_START: a non-FRAME_START valid beat on active_sel SHALL be discarded. The first such beat after entering WAIT_START increments drop_count once.
REQ-020 WAIT_START: a changed sel_req SHALL be applied immediately (active_sel<=sel_req). An invalid sel_req or enable=0 SHALL return the block to IDLE.
REQ-021 PASS: forward every valid beat of active_sel unchanged. Beats from other sources are ignored.
REQ-022 PASS: on a forwarded FRAME_END beat, increment frame_count. Then:
- enable=0 or sel_req invalid: go to IDLE.
- otherwise: go to WAIT_START with active_sel<=sel_req.
REQ-023 PASS: sel_req and enable changes SHALL NOT affect the current frame. A frame is never truncated or spliced.
REQ-024 Latency: exactly 1 cycle from an accepted input beat to dvo.
REQ-025 dtypeo and datao SHALL hold their value when dvo=0.
REQ-026 FRAME_START while already in PASS (missing FRAME_END): forward it, increment drop_count, and stay in PASS.
REQ-027 switch_pending is combinational: (sel_req!=active_sel) and state!=IDLE.
REQ-028 FRAME_END in the same cycle as a sel_req change: the new sel_req SHALL be the value latched.

Reset
REQ-029 Reset SHALL set: state=IDLE, dvo=0, dtypeo=0, datao=0, active_sel=0, frame_count=0, drop_count=0.
REQ-030 Reset asserted mid-frame SHALL drop dvo in the same cycle, without waiting for a clock edge.
REQ-031 After reset release, the block SHALL restart from IDLE. Any partial frame on a source is handled by WAIT_START discard.

Structure
REQ-032 FRAME_START, FRAME_END and `DTYPE_WIDTH SHALL come from the shared dtypes definitions. No local dtype literals.
REQ-033 Shared package holds: state encoding constants and count width (16).
REQ-034 Sub-module: stream_frame_mux_sel. It is a combinational NUM_SRC:1 slice selector for dvi/dtypei/datai indexed by active_sel. All other logic stays in the top.

Verification
REQ-035 Frame passthrough: sel_req=0, enable=1, source 0 sends one 4x4 frame. Result: dvo sequence matches the input delayed 1 cycle; frame_count=1; drop_count=0.
REQ-036 Deferred switch: sel_req changes 0->1 mid-frame on source 0. Result: source 0 frame completes intact; switch_pending=1 until its FRAME_END; active_sel=1 on the next cycle.
REQ-037 Mid-frame join: switch to source 1 while source 1 is mid-frame. Result: beats discarded until its FRAME_START; drop_count=1; the next full frame is forwarded.
REQ-038 Disable: enable=0 mid-frame. Result: frame finishes; state IDLE; dvo=0 afterwards even though sources keep streaming.
REQ-039 Async reset: assert reset mid-frame, between clock edges. Result: dvo=0 immediately; counters=0. After release, the first frame passes once a FRAME_START arrives.
REQ-040 Counter boundaries: preload via 65535 frames, or force. Result: frame_count wraps to 0 and drop_count holds at 0xFFFF. sel_req=3 with NUM_SRC=3 keeps the block in IDLE.

Source files
------------

// File: rtl/stream_frame_mux_pkg.sv
// Shared stream dtype codes, FSM state encoding and counter width for
// the frame-aware source multiplexer.
`ifndef STREAM_FRAME_MUX_DTYPES
`define STREAM_FRAME_MUX_DTYPES
`define DTYPE_WIDTH 2
`define DTYPE_DATA  2'd0
`define FRAME_START 2'd1
`define FRAME_END   2'd2
`endif

package stream_frame_mux_pkg;

    localparam int COUNT_WIDTH = 16;
    localparam int DTYPE_WIDTH = `DTYPE_WIDTH;

    typedef logic [DTYPE_WIDTH-1:0] dtype_t;
    typedef logic [COUNT_WIDTH-1:0] count_t;

    localparam dtype_t DT_DATA        = `DTYPE_DATA;
    localparam dtype_t DT_FRAME_START = `FRAME_START;
    localparam dtype_t DT_FRAME_END   = `FRAME_END;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_WAIT_START = 2'd1;
    localparam logic [1:0] ST_PASS       = 2'd2;

    function automatic count_t sat_inc(input count_t value);
        return (value == '1) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/stream_frame_mux_if.sv
// Bundle of the per-source input streams and the single muxed output stream.
interface stream_frame_mux_if
    import stream_frame_mux_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_SRC    = 3
);

    logic [NUM_SRC-1:0]             dvi;
    logic [NUM_SRC*DTYPE_WIDTH-1:0] dtypei;
    logic [NUM_SRC*DATA_WIDTH-1:0]  datai;

    logic                           dvo;
    dtype_t                         dtypeo;
    logic [DATA_WIDTH-1:0]          datao;

    modport master (
        output dvi, dtypei, datai,
        input  dvo, dtypeo, datao
    );

    modport slave (
        input  dvi, dtypei, datai,
        output dvo, dtypeo, datao
    );

endinterface

// File: rtl/stream_frame_mux_sel.sv
// Combinational NUM_SRC:1 slice selector; an out-of-range index yields an
// idle, all-zero beat.
module stream_frame_mux_sel
    import stream_frame_mux_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_SRC    = 3,
    parameter int SEL_WIDTH  = 2
) (
    input  logic [SEL_WIDTH-1:0]            sel,
    input  logic [NUM_SRC-1:0]              dvi,
    input  logic [NUM_SRC*DTYPE_WIDTH-1:0]  dtypei,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]   datai,
    output logic                            dv,
    output dtype_t                          dtype,
    output logic [DATA_WIDTH-1:0]           data
);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        dv    = 1'b0;
        dtype = '0;
        data  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (sel == SEL_WIDTH'(k)) begin
                dv    = dvi[k];
                dtype = dtypei[k*DTYPE_WIDTH +: DTYPE_WIDTH];
                data  = datai[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/stream_frame_mux.sv
// Frame-aware stream multiplexer: source switches and enable changes only
// take effect on frame boundaries, so frames are never truncated or spliced.
module stream_frame_mux
    import stream_frame_mux_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_SRC    = 3,
    parameter int SEL_WIDTH  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [SEL_WIDTH-1:0]   sel_req,
    stream_frame_mux_if.slave      bus,
    output logic [SEL_WIDTH-1:0]   active_sel,
    output logic                   switch_pending,
    output count_t                 frame_count,
    output count_t                 drop_count
);

    logic [1:0]            state;
    logic                  drop_armed;
    logic                  src_dv;
    dtype_t                src_dtype;
    logic [DATA_WIDTH-1:0] src_data;
    logic                  sel_ok;
    logic                  is_start;
    logic                  is_end;

    stream_frame_mux_sel #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_SRC    (NUM_SRC),
        .SEL_WIDTH  (SEL_WIDTH)
    ) u_sel (
        .sel    (active_sel),
        .dvi    (bus.dvi),
        .dtypei (bus.dtypei),
        .datai  (bus.datai),
        .dv     (src_dv),
        .dtype  (src_dtype),
        .data   (src_data)
    );

    assign sel_ok         = 32'(sel_req) < NUM_SRC;
    assign is_start       = src_dv && (src_dtype == DT_FRAME_START);
    assign is_end         = src_dv && (src_dtype == DT_FRAME_END);
    assign switch_pending = (sel_req != active_sel) && (state != ST_IDLE);

    // drop_armed limits WAIT_START discards to one drop_count step per entry.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            state       <= ST_IDLE;
            drop_armed  <= 1'b0;
            active_sel  <= '0;
            frame_count <= '0;
            drop_count  <= '0;
            bus.dvo     <= 1'b0;
            bus.dtypeo  <= '0;
            bus.datao   <= '0;
        end else begin
            bus.dvo <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable && sel_ok) begin
                        state      <= ST_WAIT_START;
                        active_sel <= sel_req;
                        drop_armed <= 1'b1;
                    end
                end

                ST_WAIT_START: begin
                    // A switch in this cycle ignores the old source's beat,
                    // so a frame can never start on a source being left.
                    if (!enable || !sel_ok) begin
                        state <= ST_IDLE;
                    end else if (sel_req != active_sel) begin
                        active_sel <= sel_req;
                    end else if (is_start) begin
                        bus.dvo    <= 1'b1;
                        bus.dtypeo <= src_dtype;
                        bus.datao  <= src_data;
                        state      <= ST_PASS;
                    end else if (src_dv && drop_armed) begin
                        drop_count <= sat_inc(drop_count);
                        drop_armed <= 1'b0;
                    end
                end

                ST_PASS: begin
                    if (src_dv) begin
                        bus.dvo    <= 1'b1;
                        bus.dtypeo <= src_dtype;
                        bus.datao  <= src_data;
                        if (is_end) begin
                            frame_count <= frame_count + 1'b1;
                            if (!enable || !sel_ok) begin
                                state <= ST_IDLE;
                            end else begin
                                state      <= ST_WAIT_START;
                                active_sel <= sel_req;
                                drop_armed <= 1'b1;
                            end
                        end else if (is_start) begin
                            drop_count <= sat_inc(drop_count);
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_frame_mux.sv
// Directed-vector bench for stream_frame_mux with default parameters.
module tb_stream_frame_mux;
    import stream_frame_mux_pkg::*;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [1:0]  sel_req;
    logic [1:0]  active_sel;
    logic        switch_pending;
    logic [15:0] frame_count;
    logic [15:0] drop_count;

    int n_pass  = 0;
    int n_total = 0;

    stream_frame_mux_if #(.DATA_WIDTH(16), .NUM_SRC(3)) bus ();

    stream_frame_mux #(
        .DATA_WIDTH (16),
        .NUM_SRC    (3),
        .SEL_WIDTH  (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .sel_req        (sel_req),
        .bus            (bus),
        .active_sel     (active_sel),
        .switch_pending (switch_pending),
        .frame_count    (frame_count),
        .drop_count     (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_src();
        bus.dvi    = '0;
        bus.dtypei = '0;
        bus.datai  = '0;
    endtask

    task automatic set_src(input int src, input dtype_t dt, input logic [15:0] d);
        bus.dvi[src]            = 1'b1;
        bus.dtypei[src*2 +: 2]  = dt;
        bus.datai[src*16 +: 16] = d;
    endtask

    task automatic beat(input int src, input dtype_t dt, input logic [15:0] d);
        clear_src();
        set_src(src, dt, d);
        tick();
    endtask

    function automatic dtype_t frame_dt(input int k, input int last);
        if (k == 0) return DT_FRAME_START;
        if (k == last) return DT_FRAME_END;
        return DT_DATA;
    endfunction

    task automatic test_reset();
        reset = 1'b0; enable = 1'b0; sel_req = 2'd0;
        clear_src();
        #1 reset = 1'b1;
        #2;
        n_total++; if (bus.dvo !== 1'b0) $display("FAIL rst_dvo: got %b want 0", bus.dvo); else n_pass++;
        n_total++; if (bus.dtypeo !== 2'd0) $display("FAIL rst_dtypeo: got %h want 0", bus.dtypeo); else n_pass++;
        n_total++; if (bus.datao !== 16'h0) $display("FAIL rst_datao: got %h want 0", bus.datao); else n_pass++;
        n_total++; if (active_sel !== 2'd0) $display("FAIL rst_active_sel: got %0d want 0", active_sel); else n_pass++;
        n_total++; if (frame_count !== 16'h0) $display("FAIL rst_frame_count: got %h want 0", frame_count); else n_pass++;
        n_total++; if (drop_count !== 16'h0) $display("FAIL rst_drop_count: got %h want 0", drop_count); else n_pass++;
        n_total++; if (switch_pending !== 1'b0) $display("FAIL rst_switch_pending: got %b want 0", switch_pending); else n_pass++;
        tick();
        tick();
        #2 reset = 1'b0;
    endtask

    task automatic test_passthrough();
        enable = 1'b1; sel_req = 2'd0;
        clear_src();
        tick();
        n_total++; if (active_sel !== 2'd0) $display("FAIL pt_active_sel: got %0d want 0", active_sel); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            beat(0, frame_dt(k, 3), 16'hA000 + 16'(k));
            n_total++; if (bus.dvo !== 1'b1) $display("FAIL pt_dvo[%0d]: got %b want 1", k, bus.dvo); else n_pass++;
            n_total++; if (bus.dtypeo !== frame_dt(k, 3)) $display("FAIL pt_dtypeo[%0d]: got %h want %h", k, bus.dtypeo, frame_dt(k, 3)); else n_pass++;
            n_total++; if (bus.datao !== 16'hA000 + 16'(k)) $display("FAIL pt_datao[%0d]: got %h want %h", k, bus.datao, 16'hA000 + 16'(k)); else n_pass++;
        end
        clear_src();
        tick();
        n_total++; if (bus.dvo !== 1'b0) $display("FAIL pt_idle_dvo: got %b want 0", bus.dvo); else n_pass++;
        n_total++; if (bus.datao !== 16'hA003) $display("FAIL pt_hold_datao: got %h want a003", bus.datao); else n_pass++;
        n_total++; if (bus.dtypeo !== DT_FRAME_END) $display("FAIL pt_hold_dtypeo: got %h want %h", bus.dtypeo, DT_FRAME_END); else n_pass++;
        n_total++; if (frame_count !== 16'd1) $display("FAIL pt_frame_count: got %0d want 1", frame_count); else n_pass++;
        n_total++; if (drop_count !== 16'd0) $display("FAIL pt_drop_count: got %0d want 0", drop_count); else n_pass++;
    endtask

    task automatic test_deferred_switch();
        beat(0, DT_FRAME_START, 16'hB000);
        n_total++; if (bus.datao !== 16'hB000) $display("FAIL ds_start_datao: got %h want b000", bus.datao); else n_pass++;
        sel_req = 2'd1;
        #1;
        n_total++; if (switch_pending !== 1'b1) $display("FAIL ds_pending_a: got %b want 1", switch_pending); else n_pass++;
        clear_src();
        set_src(0, DT_DATA, 16'hB001);
        set_src(1, DT_DATA, 16'hC0DE);
        tick();
        n_total++; if (bus.datao !== 16'hB001) $display("FAIL ds_mid_datao: got %h want b001", bus.datao); else n_pass++;
        n_total++; if (active_sel !== 2'd0) $display("FAIL ds_mid_active_sel: got %0d want 0", active_sel); else n_pass++;
        n_total++; if (switch_pending !== 1'b1) $display("FAIL ds_pending_b: got %b want 1", switch_pending); else n_pass++;
        beat(0, DT_FRAME_END, 16'hB002);
        n_total++; if (bus.dvo !== 1'b1) $display("FAIL ds_end_dvo: got %b want 1", bus.dvo); else n_pass++;
        n_total++; if (bus.datao !== 16'hB002) $display("FAIL ds_end_datao: got %h want b002", bus.datao); else n_pass++;
        n_total++; if (active_sel !== 2'd1) $display("FAIL ds_active_sel: got %0d want 1", active_sel); else n_pass++;
        n_total++; if (switch_pending !== 1'b0) $display("FAIL ds_pending_c: got %b want 0", switch_pending); else n_pass++;
        n_total++; if (frame_count !== 16'd2) $display("FAIL ds_frame_count: got %0d want 2", frame_count); else n_pass++;
    endtask

    task automatic test_mid_join();
        for (int k = 1; k < 4; k++) begin
            beat(1, frame_dt(k, 3), 16'h1100 + 16'(k));
            n_total++; if (bus.dvo !== 1'b0) $display("FAIL mj_discard_dvo[%0d]: got %b want 0", k, bus.dvo); else n_pass++;
        end
        n_total++; if (drop_count !== 16'd1) $display("FAIL mj_drop_count: got %0d want 1", drop_count); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            beat(1, frame_dt(k, 3), 16'h1200 + 16'(k));
            n_total++; if (bus.dvo !== 1'b1 || bus.datao !== 16'h1200 + 16'(k)) $display("FAIL mj_fwd[%0d]: got dvo=%b data=%h want dvo=1 data=%h", k, bus.dvo, bus.datao, 16'h1200 + 16'(k)); else n_pass++;
        end
        n_total++; if (frame_count !== 16'd3) $display("FAIL mj_frame_count: got %0d want 3", frame_count); else n_pass++;
    endtask

    task automatic test_frame_restart();
        beat(1, DT_FRAME_START, 16'h1300);
        beat(1, DT_DATA, 16'h1301);
        beat(1, DT_FRAME_START, 16'h1302);
        n_total++; if (bus.dvo !== 1'b1 || bus.dtypeo !== DT_FRAME_START) $display("FAIL fr_restart_fwd: got dvo=%b dtype=%h want dvo=1 dtype=%h", bus.dvo, bus.dtypeo, DT_FRAME_START); else n_pass++;
        n_total++; if (drop_count !== 16'd2) $display("FAIL fr_drop_count: got %0d want 2", drop_count); else n_pass++;
        beat(1, DT_DATA, 16'h1303);
        sel_req = 2'd0;
        beat(1, DT_FRAME_END, 16'h1304);
        n_total++; if (bus.datao !== 16'h1304) $display("FAIL fr_end_datao: got %h want 1304", bus.datao); else n_pass++;
        n_total++; if (frame_count !== 16'd4) $display("FAIL fr_frame_count: got %0d want 4", frame_count); else n_pass++;
        n_total++; if (active_sel !== 2'd0) $display("FAIL fr_latched_sel: got %0d want 0", active_sel); else n_pass++;
    endtask

    task automatic test_disable();
        beat(0, DT_FRAME_START, 16'h1400);
        enable = 1'b0;
        beat(0, DT_DATA, 16'h1401);
        n_total++; if (bus.dvo !== 1'b1 || bus.datao !== 16'h1401) $display("FAIL dis_mid: got dvo=%b data=%h want dvo=1 data=1401", bus.dvo, bus.datao); else n_pass++;
        beat(0, DT_FRAME_END, 16'h1402);
        n_total++; if (bus.dvo !== 1'b1 || bus.datao !== 16'h1402) $display("FAIL dis_end: got dvo=%b data=%h want dvo=1 data=1402", bus.dvo, bus.datao); else n_pass++;
        n_total++; if (frame_count !== 16'd5) $display("FAIL dis_frame_count: got %0d want 5", frame_count); else n_pass++;
        beat(0, DT_FRAME_START, 16'h1500);
        n_total++; if (bus.dvo !== 1'b0) $display("FAIL dis_idle_dvo_a: got %b want 0", bus.dvo); else n_pass++;
        beat(0, DT_DATA, 16'h1501);
        n_total++; if (bus.dvo !== 1'b0) $display("FAIL dis_idle_dvo_b: got %b want 0", bus.dvo); else n_pass++;
        n_total++; if (bus.datao !== 16'h1402) $display("FAIL dis_hold_datao: got %h want 1402", bus.datao); else n_pass++;
        sel_req = 2'd1;
        #1;
        n_total++; if (switch_pending !== 1'b0) $display("FAIL dis_idle_pending: got %b want 0", switch_pending); else n_pass++;
    endtask

    task automatic test_async_reset();
        enable = 1'b1;
        clear_src();
        tick();
        beat(1, DT_FRAME_START, 16'h1600);
        n_total++; if (bus.dvo !== 1'b1) $display("FAIL ar_pre_dvo: got %b want 1", bus.dvo); else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_total++; if (bus.dvo !== 1'b0) $display("FAIL ar_dvo: got %b want 0", bus.dvo); else n_pass++;
        n_total++; if (frame_count !== 16'd0 || drop_count !== 16'd0) $display("FAIL ar_counts: got fc=%0d dc=%0d want 0/0", frame_count, drop_count); else n_pass++;
        n_total++; if (active_sel !== 2'd0 || bus.datao !== 16'h0) $display("FAIL ar_regs: got sel=%0d data=%h want 0/0", active_sel, bus.datao); else n_pass++;
        tick();
        #2 reset = 1'b0;
        beat(1, DT_DATA, 16'h1601);
        n_total++; if (bus.dvo !== 1'b0 || drop_count !== 16'd0) $display("FAIL ar_idle: got dvo=%b dc=%0d want 0/0", bus.dvo, drop_count); else n_pass++;
        beat(1, DT_DATA, 16'h1602);
        beat(1, DT_FRAME_END, 16'h1603);
        n_total++; if (bus.dvo !== 1'b0 || drop_count !== 16'd1) $display("FAIL ar_discard: got dvo=%b dc=%0d want 0/1", bus.dvo, drop_count); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            beat(1, frame_dt(k, 3), 16'h1700 + 16'(k));
            n_total++; if (bus.dvo !== 1'b1 || bus.datao !== 16'h1700 + 16'(k)) $display("FAIL ar_fwd[%0d]: got dvo=%b data=%h want dvo=1 data=%h", k, bus.dvo, bus.datao, 16'h1700 + 16'(k)); else n_pass++;
        end
        n_total++; if (frame_count !== 16'd1) $display("FAIL ar_frame_count: got %0d want 1", frame_count); else n_pass++;
    endtask

    task automatic test_counter_bounds();
        beat(1, DT_FRAME_START, 16'h1800);
        force dut.frame_count = 16'hFFFF;
        #1;
        release dut.frame_count;
        for (int i = 0; i < 65534; i++) beat(1, DT_FRAME_START, 16'h1801);
        n_total++; if (drop_count !== 16'hFFFF) $display("FAIL cb_drop_max: got %h want ffff", drop_count); else n_pass++;
        beat(1, DT_FRAME_START, 16'h1802);
        beat(1, DT_FRAME_START, 16'h1803);
        n_total++; if (drop_count !== 16'hFFFF) $display("FAIL cb_drop_sat: got %h want ffff", drop_count); else n_pass++;
        sel_req = 2'd3;
        beat(1, DT_FRAME_END, 16'h18FF);
        n_total++; if (frame_count !== 16'h0) $display("FAIL cb_frame_wrap: got %h want 0", frame_count); else n_pass++;
        n_total++; if (bus.dvo !== 1'b1 || bus.datao !== 16'h18FF) $display("FAIL cb_end_fwd: got dvo=%b data=%h want dvo=1 data=18ff", bus.dvo, bus.datao); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            beat(1, DT_FRAME_START, 16'h1900 + 16'(k));
            n_total++; if (bus.dvo !== 1'b0 || switch_pending !== 1'b0) $display("FAIL cb_bad_sel_idle[%0d]: got dvo=%b pend=%b want 0/0", k, bus.dvo, switch_pending); else n_pass++;
        end
        n_total++; if (active_sel !== 2'd1) $display("FAIL cb_active_sel: got %0d want 1", active_sel); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_deferred_switch();
        test_mid_join();
        test_frame_restart();
        test_disable();
        test_async_reset();
        test_counter_bounds();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
